// File: rtl/rv32im_pkg.sv
// Shared constants for the rv32im bus fabric: Wishbone sel width and the
// arbiter state encoding.
package rv32im_pkg;

    localparam int WB_SEL_W = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'b00;
    localparam arb_state_t ARB_OWNED = 2'b01;
    localparam arb_state_t ARB_DRAIN = 2'b10;

endpackage

// File: rtl/rv32im_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1, wrapping modulo N. Returns one-hot grant, its index and a hit flag.
module rv32im_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Offset 1..N so that 'last' itself is considered only after everyone else.
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last) + i) % N);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master port between
// NUM_MASTERS requesters, with a stall watchdog that turns a hung slave into err.
module rv32im_bus_arbiter
    import rv32im_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int XLEN        = 32,
    parameter int TIMEOUT_LEN = 8,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_MASTERS-1:0]          req_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
    input  logic [NUM_MASTERS*XLEN-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    output logic [XLEN-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [XLEN-3:0]                 s_adr_o,
    output logic [XLEN-1:0]                 s_dat_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic                            s_we_o,
    output logic                            s_stb_o,
    output logic                            s_cyc_o,
    input  logic [XLEN-1:0]                 s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [IDX_W-1:0]                owner_o
);

    localparam int AW = XLEN - 2;
    // Firing on the cycle the count would step to all-ones gives exactly
    // 2**TIMEOUT_LEN-1 stalled strobe cycles before err.
    localparam logic [TIMEOUT_LEN-1:0] WD_TERM = ~TIMEOUT_LEN'(1);

    arb_state_t               state_q;
    logic [NUM_MASTERS-1:0]   grant_q;
    logic [IDX_W-1:0]         owner_q;
    logic [IDX_W-1:0]         last_q;
    logic [TIMEOUT_LEN-1:0]   wd_q;

    logic [NUM_MASTERS-1:0]   pick_gnt;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;

    logic                     gnt_any;
    logic                     owner_req;
    logic                     stalled;
    logic                     wd_fire;

    logic [NUM_MASTERS-1:0][AW-1:0]       adr_arr;
    logic [NUM_MASTERS-1:0][XLEN-1:0]     dat_arr;
    logic [NUM_MASTERS-1:0][WB_SEL_W-1:0] sel_arr;

    rv32im_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_master
        assign adr_arr[k] = m_adr_i[k*AW +: AW];
        assign dat_arr[k] = m_dat_i[k*XLEN +: XLEN];
        assign sel_arr[k] = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
        assign m_ack_o[k] = s_ack_i & grant_q[k];
        assign m_err_o[k] = (s_err_i | wd_fire) & grant_q[k];
    end

    // Grant is empty in IDLE and DRAIN, so everything below gates off there.
    assign gnt_any   = |grant_q;
    assign owner_req = req_i[owner_q];

    assign s_adr_o = gnt_any ? adr_arr[owner_q] : '0;
    assign s_dat_o = gnt_any ? dat_arr[owner_q] : '0;
    assign s_sel_o = gnt_any ? sel_arr[owner_q] : '0;
    assign s_we_o  = gnt_any & m_we_i[owner_q];
    assign s_stb_o = gnt_any & m_stb_i[owner_q];
    assign s_cyc_o = gnt_any;
    assign m_dat_o = s_dat_i;

    assign grant_o = grant_q;
    assign owner_o = owner_q;

    assign stalled = s_stb_o & ~s_ack_i & ~s_err_i;
    assign wd_fire = (state_q == ARB_OWNED) & stalled & (wd_q == WD_TERM);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        owner_q <= pick_idx;
                        state_q <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    if (wd_fire) begin
                        grant_q <= '0;
                        state_q <= ARB_DRAIN;
                    end else if (!owner_req) begin
                        grant_q <= '0;
                        last_q  <= owner_q;
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_DRAIN: begin
                    // Hold the bus idle until the timed-out master lets go.
                    if (!owner_req) begin
                        last_q  <= owner_q;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_q <= '0;
        end else if ((state_q != ARB_OWNED) || !stalled || wd_fire) begin
            wd_q <= '0;
        end else if (wd_q != '1) begin
            wd_q <= wd_q + TIMEOUT_LEN'(1);
        end
    end

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Directed bench for rv32im_bus_arbiter: two masters, 3-bit watchdog.
module tb_rv32im_bus_arbiter;

    localparam int NM = 2;
    localparam int XL = 32;
    localparam int TL = 3;
    localparam int AW = XL - 2;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic [NM-1:0]     req_i = '0;
    logic [NM-1:0]     grant_o;
    logic [NM*AW-1:0]  m_adr_i = '0;
    logic [NM*XL-1:0]  m_dat_i = '0;
    logic [NM*4-1:0]   m_sel_i = '0;
    logic [NM-1:0]     m_we_i = '0;
    logic [NM-1:0]     m_stb_i = '0;
    logic [XL-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [XL-1:0]     s_dat_o;
    logic [3:0]        s_sel_o;
    logic              s_we_o;
    logic              s_stb_o;
    logic              s_cyc_o;
    logic [XL-1:0]     s_dat_i = '0;
    logic              s_ack_i = 1'b0;
    logic              s_err_i = 1'b0;
    logic [0:0]        owner_o;

    int checks = 0;
    int failures = 0;

    rv32im_bus_arbiter #(
        .NUM_MASTERS (NM),
        .XLEN        (XL),
        .TIMEOUT_LEN (TL)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   (req_i),
        .grant_o (grant_o),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_stb_o (s_stb_o),
        .s_cyc_o (s_cyc_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .owner_o (owner_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        checks++;
        if ({grant_o, owner_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== 8'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%b owner=%b cyc=%b stb=%b ack=%b err=%b, want all 0",
                     grant_o, owner_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
        end
        reset_i = 1'b0;
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL idle_no_req: grant=%b want 00", grant_o);
        end
    endtask

    task automatic test_single();
        req_i = 2'b01;
        tick();
        checks++;
        if (grant_o !== 2'b01 || owner_o !== 1'b0 || s_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: grant=%b owner=%b cyc=%b want 01/0/1", grant_o, owner_o, s_cyc_o);
        end
        m_adr_i[0 +: AW] = 30'h100;
        m_dat_i[0 +: XL] = 32'hCAFE_0001;
        m_sel_i[3:0]     = 4'hF;
        m_we_i           = 2'b01;
        m_stb_i          = 2'b01;
        #1;
        checks++;
        if (s_adr_o !== 30'h100 || s_dat_o !== 32'hCAFE_0001 || s_sel_o !== 4'hF
            || s_we_o !== 1'b1 || s_stb_o !== 1'b1 || m_ack_o !== 2'b00) begin
            failures++;
            $display("FAIL single_mux: adr=%h dat=%h sel=%h we=%b stb=%b ack=%b want 100/cafe0001/f/1/1/00",
                     s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, m_ack_o);
        end
        tick();
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h1234_5678;
        #1;
        checks++;
        if (m_ack_o !== 2'b01 || m_dat_o !== 32'h1234_5678) begin
            failures++;
            $display("FAIL single_ack: ack=%b dat=%h want 01/12345678", m_ack_o, m_dat_o);
        end
        tick();
        s_ack_i = 1'b0;
        m_stb_i = 2'b00;
        m_we_i  = 2'b00;
        req_i   = 2'b00;
        tick();
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_adr_o !== '0) begin
            failures++;
            $display("FAIL single_release: grant=%b cyc=%b adr=%h want 00/0/0", grant_o, s_cyc_o, s_adr_o);
        end
    endtask

    task automatic test_tie();
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
        req_i = 2'b11;
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("FAIL tie_first: grant=%b want 01", grant_o);
        end
        req_i = 2'b10;
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL tie_dead_cycle: grant=%b want 00", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b10 || owner_o !== 1'b1) begin
            failures++;
            $display("FAIL tie_handover: grant=%b owner=%b want 10/1", grant_o, owner_o);
        end
        req_i = 2'b00;
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL tie_release: grant=%b want 00", grant_o);
        end
    endtask

    // Owner drops req in its ack cycle, re-raises during the dead cycle.
    task automatic test_fairness();
        logic [1:0] exp;
        req_i = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp = (n % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (grant_o !== exp) begin
                failures++;
                $display("FAIL fair_grant[%0d]: grant=%b want %b", n, grant_o, exp);
            end
            m_stb_i = exp;
            s_ack_i = 1'b1;
            req_i   = 2'b11 & ~exp;
            #1;
            checks++;
            if (m_ack_o !== exp) begin
                failures++;
                $display("FAIL fair_ack_on_drop[%0d]: ack=%b want %b", n, m_ack_o, exp);
            end
            tick();
            m_stb_i = 2'b00;
            s_ack_i = 1'b0;
            checks++;
            if (grant_o !== 2'b00) begin
                failures++;
                $display("FAIL fair_dead[%0d]: grant=%b want 00", n, grant_o);
            end
            if (n == 1) begin
                s_ack_i = 1'b1;
                s_err_i = 1'b1;
                #1;
                checks++;
                if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
                    failures++;
                    $display("FAIL no_owner_ignore: ack=%b err=%b want 00/00", m_ack_o, m_err_o);
                end
                s_ack_i = 1'b0;
                s_err_i = 1'b0;
            end
            req_i = (n == 3) ? 2'b00 : 2'b11;
        end
        tick();
    endtask

    task automatic test_watchdog();
        req_i = 2'b10;
        tick();
        checks++;
        if (grant_o !== 2'b10) begin
            failures++;
            $display("FAIL wd_grant: grant=%b want 10", grant_o);
        end
        m_stb_i = 2'b10;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) req_i = 2'b11;
            #1;
            checks++;
            if (m_err_o !== ((c == 7) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL wd_err[%0d]: err=%b want %b", c, m_err_o, (c == 7) ? 2'b10 : 2'b00);
            end
            if (c < 7) tick();
        end
        tick();
        checks++;
        if (grant_o !== 2'b00 || m_err_o !== 2'b00 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL wd_drain: grant=%b err=%b stb=%b cyc=%b want 00/00/0/0",
                     grant_o, m_err_o, s_stb_o, s_cyc_o);
        end
        tick();
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL wd_drain_hold: grant=%b want 00", grant_o);
        end
        req_i   = 2'b01;
        m_stb_i = 2'b00;
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL wd_exit_idle: grant=%b want 00", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b01 || owner_o !== 1'b0) begin
            failures++;
            $display("FAIL wd_next_owner: grant=%b owner=%b want 01/0", grant_o, owner_o);
        end
    endtask

    // Master 0 already owns the bus; three stalls, an err, then six more stalls.
    task automatic test_slave_err();
        m_stb_i = 2'b01;
        tick();
        tick();
        tick();
        s_err_i = 1'b1;
        #1;
        checks++;
        if (m_err_o !== 2'b01 || m_ack_o !== 2'b00) begin
            failures++;
            $display("FAIL slave_err: err=%b ack=%b want 01/00", m_err_o, m_ack_o);
        end
        tick();
        s_err_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("FAIL err_keep_grant: grant=%b want 01", grant_o);
        end
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (m_err_o !== 2'b00) begin
                failures++;
                $display("FAIL err_wd_cleared[%0d]: err=%b want 00", c, m_err_o);
            end
            if (c < 6) tick();
        end
        s_ack_i = 1'b1;
        req_i   = 2'b00;
        tick();
        s_ack_i = 1'b0;
        m_stb_i = 2'b00;
        tick();
    endtask

    task automatic test_req_pulse();
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        #1;
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("FAIL pulse_grant: grant=%b want 01", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL pulse_release: grant=%b want 00", grant_o);
        end
        req_i = 2'b01;
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("FAIL alone_regrant: grant=%b want 01", grant_o);
        end
        req_i = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        req_i = 2'b10;
        tick();
        m_stb_i = 2'b10;
        #1;
        checks++;
        if (grant_o !== 2'b10 || s_stb_o !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: grant=%b stb=%b want 10/1", grant_o, s_stb_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || owner_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: grant=%b stb=%b cyc=%b owner=%b want 00/0/0/0",
                     grant_o, s_stb_o, s_cyc_o, owner_o);
        end
        m_stb_i = 2'b00;
        req_i   = 2'b11;
        tick();
        reset_i = 1'b0;
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_priority: grant=%b want 01", grant_o);
        end
        req_i = 2'b00;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_watchdog();
        test_slave_err();
        test_req_pulse();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
